pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It generalises the fixed two-word IF/ID latch into a reusable stage for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) of arbitrary payload width. Stall is expressed as back-pressure: the downstream stage deasserts Out_Ready. The hazard unit drives Flush on branch or jump redirect.

---
 rtl/pipe_stage_reg_if.sv | 26 ++
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data, downstream valid/ready/data,
// flush and status. The slave modport is the stage's view; master is the surrounding logic's view.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              In_Valid;
  logic              In_Ready;
  logic [DATA_W-1:0] In_Data;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [DATA_W-1:0] Out_Data;
  logic              Flush;
  logic [1:0]        Occupancy;
  logic [CNT_W-1:0]  Stall_Count;

  modport slave (
    input  In_Valid, In_Data, Out_Ready, Flush,
    output In_Ready, Out_Valid, Out_Data, Occupancy, Stall_Count
  );

  modport master (
    output In_Valid, In_Data, Out_Ready, Flush,
    input  In_Ready, Out_Valid, Out_Data, Occupancy, Stall_Count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer and synchronous flush.
// Optional back-pressure counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  pipe_stage_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        occupancy_q, occupancy_d;
  logic              in_fire;
  logic              out_fire;

  // Handshake qualifiers use only registered outputs, so no input-to-ready path exists.
  assign in_fire  = bus.In_Valid & in_ready_q;
  assign out_fire = out_valid_q & bus.Out_Ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.Flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_d  = bus.In_Data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = bus.In_Data;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = bus.In_Data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    unique case (state_d)
      ST_BUSY: occupancy_d = 2'd1;
      ST_FULL: occupancy_d = 2'd2;
      default: occupancy_d = 2'd0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign bus.In_Ready  = in_ready_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Out_Data  = main_q;
  assign bus.Occupancy = occupancy_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counts stalled cycles regardless of Flush; saturates instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !bus.Out_Ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.Stall_Count = stall_cnt_q;
`else
  assign bus.Stall_Count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random self-checking bench for pipe_stage_reg (small payload, 2-bit stall counter).
module tb_pipe_stage_reg;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic              ordy;
    logic              fl;
    logic              e_ov;
    logic [DATA_W-1:0] e_od;
    logic              chk_od;
    logic              e_ir;
    logic [1:0]        e_occ;
  } vec_t;

  vec_t vecs[20];
  logic [DATA_W-1:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    Reset_n      = 1'b0;
    bus.In_Valid  = 1'b0;
    bus.In_Data   = '0;
    bus.Out_Ready = 1'b0;
    bus.Flush     = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  function automatic logic [CNT_W-1:0] exp_stall(input int n);
`ifdef PIPE_STAGE_STALL_CNT_EN
    return (n > 3) ? CNT_W'(3) : CNT_W'(n);
`else
    return (n > 3) ? '0 : '0;
`endif
  endfunction

  // One random-handshake cycle against a FIFO scoreboard.
  task automatic rand_step(input logic iv, input logic ordy, input logic [DATA_W-1:0] d);
    logic in_fire, out_fire;
    @(negedge Clk);
    chk("occ_model", bus.Occupancy, 32'(sb_q.size()));
    chk("ir_model", bus.In_Ready, sb_q.size() != 2);
    chk("ov_model", bus.Out_Valid, sb_q.size() != 0);
    bus.In_Valid  = iv;
    bus.Out_Ready = ordy;
    bus.In_Data   = d;
    #1;
    in_fire  = iv & bus.In_Ready;
    out_fire = bus.Out_Valid & ordy;
    if (out_fire) begin
      if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("order", bus.Out_Data, sb_q.pop_front());
    end
    if (in_fire) sb_q.push_back(d);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 2'd1};
    vecs[1]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 2'd1};
    vecs[2]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 2'd1};
    vecs[3]  = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0};
    vecs[5]  = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b0, 2'd2};
    vecs[7]  = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b0, 2'd2};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000B, 1'b1, 1'b1, 2'd1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0};
    vecs[10] = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b1, 2'd1};
    vecs[11] = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b0, 2'd2};
    vecs[12] = '{1'b1, 16'h000C, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 2'd0};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2'd0};
    vecs[14] = '{1'b1, 16'h000D, 1'b1, 1'b0, 1'b1, 16'h000D, 1'b1, 1'b1, 2'd1};
    vecs[15] = '{1'b1, 16'h000E, 1'b0, 1'b0, 1'b1, 16'h000D, 1'b1, 1'b0, 2'd2};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 2'd0};
    vecs[17] = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b1, 2'd1};
    vecs[18] = '{1'b1, 16'h0006, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 2'd0};
    vecs[19] = '{1'b1, 16'h0007, 1'b1, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b1, 2'd1};

    do_reset();
    #1;
    chk("rst_ov", bus.Out_Valid, 1'b0);
    chk("rst_od", bus.Out_Data, '0);
    chk("rst_ir", bus.In_Ready, 1'b1);
    chk("rst_occ", bus.Occupancy, 2'd0);
    chk("rst_stall", bus.Stall_Count, '0);

    foreach (vecs[i]) begin
      @(negedge Clk);
      bus.In_Valid  = vecs[i].iv;
      bus.In_Data   = vecs[i].d;
      bus.Out_Ready = vecs[i].ordy;
      bus.Flush     = vecs[i].fl;
      @(posedge Clk);
      #1;
      $display("vec %0d: iv=%0b d=%0h ordy=%0b fl=%0b -> ov=%0b od=%0h ir=%0b occ=%0d",
               i, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl,
               bus.Out_Valid, bus.Out_Data, bus.In_Ready, bus.Occupancy);
      chk($sformatf("v%0d_ov", i), bus.Out_Valid, vecs[i].e_ov);
      if (vecs[i].chk_od) chk($sformatf("v%0d_od", i), bus.Out_Data, vecs[i].e_od);
      chk($sformatf("v%0d_ir", i), bus.In_Ready, vecs[i].e_ir);
      chk($sformatf("v%0d_occ", i), bus.Occupancy, vecs[i].e_occ);
    end
    @(negedge Clk);
    bus.Flush = 1'b0;

    // Asynchronous reset while holding a payload.
    do_reset();
    @(negedge Clk);
    bus.In_Valid = 1'b1; bus.In_Data = 16'h0055; bus.Out_Ready = 1'b0;
    @(posedge Clk);
    #1;
    chk("ar_hold_od", bus.Out_Data, 16'h0055);
    @(negedge Clk);
    bus.In_Valid = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    $display("async reset: ov=%0b od=%0h ir=%0b occ=%0d", bus.Out_Valid, bus.Out_Data, bus.In_Ready, bus.Occupancy);
    chk("ar_ov", bus.Out_Valid, 1'b0);
    chk("ar_od", bus.Out_Data, '0);
    chk("ar_ir", bus.In_Ready, 1'b1);
    chk("ar_occ", bus.Occupancy, 2'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Stall counter: accept one payload, then hold it under back-pressure.
    do_reset();
    @(negedge Clk);
    bus.In_Valid = 1'b1; bus.In_Data = 16'h0077; bus.Out_Ready = 1'b0;
    @(posedge Clk);
    #1;
    chk("stall_0", bus.Stall_Count, '0);
    @(negedge Clk);
    bus.In_Valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge Clk);
      #1;
      $display("stall cycle %0d: Stall_Count=%0d", k, bus.Stall_Count);
      chk($sformatf("stall_%0d", k), bus.Stall_Count, exp_stall(k));
    end
    chk("stall_od_held", bus.Out_Data, 16'h0077);

    // Random handshake against the scoreboard, then drain.
    do_reset();
    sb_q.delete();
    for (int n = 0; n < 1000; n++) begin
      rand_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom));
    end
    for (int n = 0; n < 4; n++) rand_step(1'b0, 1'b1, '0);
    @(negedge Clk);
    chk("drain_occ", bus.Occupancy, 32'(sb_q.size()));
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    $display("random handshake done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
